spiflash_programmer: RTL and testbench
======================================

Name: spiflash_programmer

Overview:
- Memory-mapped SPI NOR write engine: the write-direction counterpart to the read-only flash controller (spimemio).
- Programs one 32-bit word per command: WREN, PAGE PROGRAM, then RDSR polling until WIP clears.
- Drives the same 6-bit flash pin group as spimemio. The top level muxes the pins to this block while `active`=1.
- Commands come from the interconnect as a single-beat valid/ready transaction.

Parameters:
- CLK_DIV, 2: SCK half-period in clk cycles (≥1). One SPI bit takes 2*CLK_DIV cycles.
- CS_GAP, 4: minimum clk cycles csb is held high between frames (≥1).
- POLL_LIMIT, 1024: maximum RDSR frames before timeout error (≥1).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; transfer on cmd_valid&&cmd_ready
- cmd_addr  in  24  flash byte address; bits [1:0] ignored (forced 0)
- cmd_wdata  in  32  word to program
- done  out  1  one-cycle pulse at end of command
- err  out  1  valid with done; 1 = poll timeout
- active  out  1  block owns the flash pins (csb asserted or in inter-frame gap)
- flash_in  in  6  [0]csb [1]sck [2]io0 [3]io1(MISO) [4]io2 [5]io3
- flash_out  out  6  same bit mapping
- flash_oeb  out  6  0 = drive

Behaviour:
- Reset state: IDLE; cmd_ready=1, done=0, err=0, active=0, flash_out=6'b000000, flash_oeb=6'b111111.
- Reset mid-operation: the asynchronous assert forces the reset state immediately and aborts the frame. No done pulse is produced.
- Pin usage while active:
  - csb, sck, io0, io2, io3 are driven (oeb=0); io1 oeb=1.
  - io2=io3=1 (WP#/HOLD# inactive).
  - While active=0: all oeb=1, all flash_out=0.
- Command capture: on acceptance, latch {cmd_addr[23:2],2'b00} and cmd_wdata. Later input changes are ignored. Inputs are ignored while cmd_ready=0.
- SPI mode 0, MSB-first per byte:
  - io0 is updated while sck is low; sck stays low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MISO is sampled on the clk edge that drives sck high.
  - csb falls in the cycle after entry to a SHIFT state, together with the first bit on io0 and sck=0.
  - After the last falling sck edge, csb rises on the next cycle; sck idles at 0.
- States:
  - IDLE → WREN (8 bits: 0x06) → GAP
  - GAP → PP (64 bits: 0x02, addr[23:16], addr[15:8], addr[7:0], wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]) → GAP
  - GAP → RDSR (8 bits out: 0x05, then 8 bits in; io0 held 0 during the input byte) → GAP → CHECK
  - CHECK: if status[0]=0 → DONE. Else if poll_count==POLL_LIMIT → DONE with err=1. Else → GAP → RDSR.
  - DONE → IDLE.
- GAP: csb=1 for exactly CS_GAP cycles; active stays 1.
- poll_count: cleared on command acceptance, incremented at each RDSR frame start.
- DONE: done=1 for one cycle, err latched. Next cycle: IDLE, active=0, cmd_ready=1.
- A new cmd_valid in the first IDLE cycle is accepted (back-to-back commands supported).
- Page-boundary crossing is impossible: aligned words never straddle a 256-byte page.
- err holds its value until the next done.
- SHIFT frame duration: 2*CLK_DIV*nbits cycles from csb fall to the last sck fall, +1 cycle to csb rise.

Test Plan:
- CLK_DIV=2, CS_GAP=4; addr 0x000104, wdata 0x11223344; slave returns status 0x00. Expect:
  - io0 bytes: 06 | 02 00 01 04 44 33 22 11 | 05.
  - Exactly 3 csb-low frames; each gap ≥4 cycles.
  - done=1, err=0.
- Slave status sequence 0x03, 0x01, 0x00 → 3 RDSR frames, then done=1, err=0.
- POLL_LIMIT=4; status stuck at 0x01 → exactly 4 RDSR frames, then done=1, err=1, active=0 the following cycle.
- cmd_addr 0x000107 → address bytes on io0 are 00 01 04.
- resetn pulsed low during the PP frame's 20th bit → same cycle: csb=1, flash_oeb=6'h3F, active=0. After release, cmd_ready=1 and no done pulse.
- Two commands with cmd_valid held high → second accepted in the IDLE cycle after done. Second WREN frame starts one cycle later; cmd_valid ignored throughout busy.

Source files
------------

// File: rtl/spiflash_programmer.sv
// -----------------------------------------------------------------------------
// spiflash_programmer
// Memory-mapped SPI NOR write engine. Each accepted command programs one
// 32-bit word: WREN, PAGE PROGRAM (opcode, 3 address bytes, 4 data bytes LSB
// first), then RDSR polling until the status WIP bit clears or the poll limit
// is reached. Drives the same 6-bit flash pin group as the read controller;
// the top level hands the pins to this block while `active` is high.
//
// Ports:
//   clk, resetn           system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   single-beat command handshake (ready only in IDLE)
//   cmd_addr[23:0]        flash byte address, bits [1:0] forced to zero
//   cmd_wdata[31:0]       word to program
//   done                  one-cycle pulse at command completion
//   err                   poll timeout flag, valid with done, held until next done
//   active                block owns the flash pins
//   flash_in/out/oeb[5:0] [0]csb [1]sck [2]io0 [3]io1(MISO) [4]io2 [5]io3
// -----------------------------------------------------------------------------
module spiflash_programmer #(
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 4,
    parameter int POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        done,
    output logic        err,
    output logic        active,
    input  logic [5:0]  flash_in,
    output logic [5:0]  flash_out,
    output logic [5:0]  flash_oeb
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_PP, S_RDSR, S_GAP, S_CHECK, S_DONE
    } state_t;

    state_t        r_state, w_next_state;
    state_t        r_after, w_after_next;   // where GAP goes once it expires
    logic [23:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [63:0]   r_shreg;                 // outgoing frame bits, MSB on io0
    logic [7:0]    r_status;
    logic [DW-1:0] r_div;
    logic          r_phase;                 // 0: sck low half, 1: sck high half
    logic [6:0]    r_bit;                   // completed bits in current frame
    logic [GW-1:0] r_gap_cnt;
    logic [PW-1:0] r_poll;
    logic          r_err;

    logic       w_in_shift, w_next_shift, w_enter_shift;
    logic       w_frame_end, w_tick, w_timeout;
    logic [6:0] w_nbits;
    logic       w_csb, w_sck, w_io0;
    logic       w_unused;

    assign w_unused = ^{cmd_addr[1:0], flash_in[5:4], flash_in[2:0]};

    assign w_in_shift    = (r_state == S_WREN) || (r_state == S_PP) || (r_state == S_RDSR);
    assign w_next_shift  = (w_next_state == S_WREN) || (w_next_state == S_PP) ||
                           (w_next_state == S_RDSR);
    assign w_enter_shift = w_next_shift && (w_next_state != r_state);
    assign w_tick        = (r_div == DW'(CLK_DIV - 1));

    always_comb begin
        case (r_state)
            S_WREN:  w_nbits = 7'd8;
            S_PP:    w_nbits = 7'd64;
            S_RDSR:  w_nbits = 7'd16;   // 8 opcode bits out, 8 status bits in
            default: w_nbits = 7'd0;
        endcase
    end

    // The frame ends in the cycle after the last falling sck edge; csb stays
    // low through it and rises when the FSM moves to GAP.
    assign w_frame_end = (r_bit == w_nbits);

    // NOTE: every combinational output gets a default first so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_after_next = r_after;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_next_state = S_WREN;
            S_WREN:  if (w_frame_end) begin w_next_state = S_GAP; w_after_next = S_PP;    end
            S_PP:    if (w_frame_end) begin w_next_state = S_GAP; w_after_next = S_RDSR;  end
            S_RDSR:  if (w_frame_end) begin w_next_state = S_GAP; w_after_next = S_CHECK; end
            S_GAP:   if (r_gap_cnt == GW'(CS_GAP - 1)) w_next_state = r_after;
            S_CHECK: begin
                if (!r_status[0]) begin
                    w_next_state = S_DONE;
                end else if (r_poll == PW'(POLL_LIMIT)) begin
                    w_next_state = S_DONE;
                    w_timeout    = 1'b1;
                end else begin
                    w_next_state = S_GAP;
                    w_after_next = S_RDSR;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_after   <= S_PP;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_shreg   <= '0;
            r_status  <= '0;
            r_div     <= '0;
            r_phase   <= 1'b0;
            r_bit     <= '0;
            r_gap_cnt <= '0;
            r_poll    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_after <= w_after_next;

            if (r_state == S_IDLE && cmd_valid) begin
                r_addr  <= {cmd_addr[23:2], 2'b00};
                r_wdata <= cmd_wdata;
                r_poll  <= '0;
            end

            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;

            if (w_enter_shift) begin
                r_div   <= '0;
                r_phase <= 1'b0;
                r_bit   <= '0;
                case (w_next_state)
                    S_WREN:  r_shreg <= {8'h06, 56'h0};
                    S_PP:    r_shreg <= {8'h02, r_addr, r_wdata[7:0], r_wdata[15:8],
                                         r_wdata[23:16], r_wdata[31:24]};
                    default: r_shreg <= {8'h05, 56'h0};  // zeros keep io0 low while reading
                endcase
                if (w_next_state == S_RDSR) r_poll <= r_poll + 1'b1;
            end else if (w_in_shift && !w_frame_end) begin
                if (!w_tick) begin
                    r_div <= r_div + 1'b1;
                end else begin
                    r_div <= '0;
                    if (!r_phase) begin
                        // This edge raises sck: sample MISO during the status byte.
                        r_phase <= 1'b1;
                        if (r_state == S_RDSR && r_bit >= 7'd8)
                            r_status <= {r_status[6:0], flash_in[3]};
                    end else begin
                        r_phase <= 1'b0;
                        r_bit   <= r_bit + 1'b1;
                        r_shreg <= {r_shreg[62:0], 1'b0};
                    end
                end
            end

            if (r_state == S_CHECK && w_next_state == S_DONE) r_err <= w_timeout;
        end
    end

    assign w_csb = ~w_in_shift;
    assign w_sck = w_in_shift & r_phase;
    assign w_io0 = w_in_shift & r_shreg[63];

    assign cmd_ready = (r_state == S_IDLE);
    assign active    = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

    // io2/io3 held high (WP#/HOLD# inactive); io1 is the only input while active.
    assign flash_out = active ? {1'b1, 1'b1, 1'b0, w_io0, w_sck, w_csb} : 6'b000000;
    assign flash_oeb = active ? 6'b001000 : 6'b111111;

endmodule

// File: tb/tb_spiflash_programmer.sv
// -----------------------------------------------------------------------------
// tb_spiflash_programmer
// Randomised self-checking bench. A behavioural model turns every accepted
// command into an expected per-cycle pin/handshake timeline (frame lengths,
// gap lengths, bit positions) plus expected frame contents; a single monitor
// compares the DUT against it each cycle, decodes io0 into bytes and plays
// the flash slave on MISO. Directed scenarios pin the model with literals.
// -----------------------------------------------------------------------------
module tb_spiflash_programmer;

    localparam int CLK_DIV    = 2;
    localparam int CS_GAP     = 4;
    localparam int POLL_LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        done;
    logic        err;
    logic        active;
    logic [5:0]  flash_in;
    logic [5:0]  flash_out;
    logic [5:0]  flash_oeb;

    spiflash_programmer #(
        .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .done(done), .err(err), .active(active),
        .flash_in(flash_in), .flash_out(flash_out), .flash_oeb(flash_oeb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic csb;
        logic sck;
        logic io0;
        logic done;
        logic err;
    } cyc_t;

    typedef struct packed {
        logic [63:0] bits;
        logic [7:0]  n;
    } frame_t;

    cyc_t       exp_q[$];
    frame_t     fr_q[$];
    logic [7:0] slave_stat[$];
    logic       m_last_err;

    function automatic logic [7:0] stat_at(input int k);
        if (slave_stat.size() == 0) return 8'h00;
        return (k < slave_stat.size()) ? slave_stat[k] : slave_stat[slave_stat.size()-1];
    endfunction

    task automatic add_frame(input logic [63:0] v, input int n);
        cyc_t e;
        int   half = CLK_DIV;
        for (int t = 0; t <= 2*half*n; t++) begin
            e.csb  = 1'b0;
            e.sck  = (t < 2*half*n) && ((t % (2*half)) >= half);
            e.io0  = (t < 2*half*n) ? v[63 - t/(2*half)] : 1'b0;
            e.done = 1'b0;
            e.err  = m_last_err;
            exp_q.push_back(e);
        end
        fr_q.push_back('{bits: v, n: 8'(n)});
    endtask

    task automatic add_high(input int n, input logic d, input logic e_err);
        cyc_t e;
        for (int t = 0; t < n; t++) begin
            e = '{csb: 1'b1, sck: 1'b0, io0: 1'b0, done: d, err: e_err};
            exp_q.push_back(e);
        end
    endtask

    task automatic build_cmd(input logic [23:0] a_in, input logic [31:0] w);
        logic [23:0] a;
        int          k;
        logic        terr;
        a    = {a_in[23:2], 2'b00};
        k    = 0;
        terr = 1'b0;
        forever begin
            k++;
            if (!stat_at(k-1)[0]) break;
            if (k == POLL_LIMIT) begin terr = 1'b1; break; end
        end
        add_frame({8'h06, 56'h0}, 8);
        add_high(CS_GAP, 1'b0, m_last_err);
        add_frame({8'h02, a, w[7:0], w[15:8], w[23:16], w[31:24]}, 64);
        add_high(CS_GAP, 1'b0, m_last_err);
        for (int i = 0; i < k; i++) begin
            add_frame({8'h05, 56'h0}, 16);
            add_high(CS_GAP + 1, 1'b0, m_last_err);          // gap + status check
            if (i < k-1) add_high(CS_GAP, 1'b0, m_last_err);
        end
        add_high(1, 1'b1, terr);
        m_last_err = terr;
    endtask

    // ---------------- monitor / slave ----------------
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_done_cyc = 0;
    int          last_rise_cyc = 0;
    int          min_gap = 1000000;
    int          fall_q[$];
    logic [7:0]  log_bytes[$];
    int          log_rdsr = 0;
    int          log_frames = 0;
    logic        in_frame;
    logic        prev_csb, prev_sck;
    int          d_nbits;
    int          d_frame_in_cmd = 0;
    int          d_rdsr_idx = 0;
    logic [63:0] d_cur;
    logic [7:0]  d_first;
    logic [7:0]  d_stat;
    logic        miso;

    always @(negedge clk) begin
        cyc_t        e;
        frame_t      fr;
        logic        idle, csb_e, sck_e, io0_e;
        logic [15:0] act_v, exp_v;
        int          nb;
        cyc++;
        act_v = {cmd_ready, done, err, active, flash_out, flash_oeb};
        if (!resetn) begin
            exp_q.delete();
            fr_q.delete();
            m_last_err = 1'b0;
            in_frame   = 1'b0;
            prev_csb   = 1'b1;
            prev_sck   = 1'b0;
            miso       = 1'b0;
            check("reset_state", act_v, {1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h3F});
        end else begin
            idle = (exp_q.size() == 0);
            if (!idle) begin
                e = exp_q.pop_front();
                exp_v = {1'b0, e.done, e.err, 1'b1, {3'b110, e.io0, e.sck, e.csb}, 6'b001000};
            end else begin
                exp_v = {1'b1, 1'b0, m_last_err, 1'b0, 6'h00, 6'h3F};
            end
            check("cycle", act_v, exp_v);
            if (done) begin done_cnt++; last_done_cyc = cyc; end

            csb_e = active ? flash_out[0] : 1'b1;
            sck_e = active & flash_out[1];
            io0_e = flash_out[2];
            if (prev_csb && !csb_e) begin
                in_frame = 1'b1;
                d_nbits  = 0;
                d_cur    = '0;
                d_frame_in_cmd++;
                if (d_frame_in_cmd == 1) fall_q.push_back(cyc - last_done_cyc);
                else if (cyc - last_rise_cyc < min_gap) min_gap = cyc - last_rise_cyc;
            end else if (in_frame && !csb_e && sck_e && !prev_sck) begin
                d_cur = {d_cur[62:0], io0_e};
                d_nbits++;
                if (d_nbits == 8) begin
                    d_first = d_cur[7:0];
                    if (d_first == 8'h05) begin
                        d_stat = stat_at(d_rdsr_idx);
                        d_rdsr_idx++;
                    end
                end
            end
            if (in_frame && csb_e && !prev_csb) begin
                in_frame      = 1'b0;
                last_rise_cyc = cyc;
                log_frames++;
                if (fr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL frame_unexpected: %0d bits seen, none expected", d_nbits);
                end else begin
                    fr = fr_q.pop_front();
                    check("frame_nbits", 64'(d_nbits), 64'(fr.n));
                    check("frame_data", d_cur, fr.bits >> (64 - int'(fr.n)));
                end
                nb = d_nbits / 8;
                if (nb > 0 && d_first == 8'h05) begin
                    log_rdsr++;
                    log_bytes.push_back(8'h05);
                end else begin
                    for (int i = 0; i < nb; i++)
                        log_bytes.push_back(8'(d_cur >> (8*(nb-1-i))));
                end
            end
            miso = (in_frame && !csb_e && d_first == 8'h05 && d_nbits >= 8 && d_nbits < 16)
                   ? d_stat[15 - d_nbits] : 1'b0;
            prev_csb = csb_e;
            prev_sck = sck_e;

            if (idle && cmd_valid) begin
                build_cmd(cmd_addr, cmd_wdata);
                d_frame_in_cmd = 0;
                d_rdsr_idx     = 0;
                d_first        = 8'h00;
            end
        end
        flash_in = {2'b00, miso, 3'b000};
    end

    // ---------------- driver ----------------
    task automatic wait_accept();
        bit seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_ready) begin seen = 1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL accept_timeout: cmd_ready stayed 0 for 200 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic [23:0] a, input logic [31:0] w);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_wdata = w;
        wait_accept();
        cmd_valid = 1'b0;
        cmd_addr  = 24'($urandom);   // later input changes must be ignored
        cmd_wdata = $urandom;
    endtask

    task automatic wait_done(output logic e_out);
        bit seen = 0;
        e_out = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout: no done within 4000 cycles");
        end else begin
            e_out = err;
            @(negedge clk);
            check("after_done_active", 64'(active), 64'(0));
            check("after_done_ready", 64'(cmd_ready), 64'(1));
        end
    endtask

    task automatic clear_logs();
        log_bytes.delete();
        log_rdsr   = 0;
        log_frames = 0;
        min_gap    = 1000000;
        fall_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic       e;
        logic [7:0] exp_b[10];
        int         dc;
        bit         hit;

        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        flash_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(cmd_ready), 64'(1));
        check("rst_pins", {flash_out, flash_oeb}, {6'h00, 6'h3F});
        resetn = 1'b1;

        // Basic program, WIP already clear.
        slave_stat = '{8'h00};
        clear_logs();
        send_cmd(24'h000104, 32'h11223344);
        wait_done(e);
        check("t1_err", 64'(e), 64'(0));
        check("t1_frames", 64'(log_frames), 64'(3));
        check("t1_gap_ge", 64'(min_gap >= CS_GAP), 64'(1));
        exp_b = '{8'h06, 8'h02, 8'h00, 8'h01, 8'h04, 8'h44, 8'h33, 8'h22, 8'h11, 8'h05};
        check("t1_nbytes", 64'(log_bytes.size()), 64'(10));
        for (int i = 0; i < 10 && i < log_bytes.size(); i++)
            check($sformatf("t1_byte%0d", i), 64'(log_bytes[i]), 64'(exp_b[i]));

        // Busy for two polls.
        slave_stat = '{8'h03, 8'h01, 8'h00};
        clear_logs();
        send_cmd(24'h123458, 32'hCAFEF00D);
        wait_done(e);
        check("t2_err", 64'(e), 64'(0));
        check("t2_rdsr", 64'(log_rdsr), 64'(3));

        // Stuck busy: poll limit reached.
        slave_stat = '{8'h01};
        clear_logs();
        send_cmd(24'h00FF00, 32'h0BADBEEF);
        wait_done(e);
        check("t3_err", 64'(e), 64'(1));
        check("t3_rdsr", 64'(log_rdsr), 64'(POLL_LIMIT));

        // Unaligned address is forced down to a word boundary.
        slave_stat = '{8'h00};
        clear_logs();
        send_cmd(24'h000107, 32'h55AA55AA);
        wait_done(e);
        check("t4_err", 64'(e), 64'(0));
        check("t4_a2", 64'(log_bytes[2]), 64'(8'h00));
        check("t4_a1", 64'(log_bytes[3]), 64'(8'h01));
        check("t4_a0", 64'(log_bytes[4]), 64'(8'h04));

        // Reset during the 20th bit of the PP frame.
        slave_stat = '{8'h00};
        send_cmd(24'h000200, 32'h01020304);
        hit = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (in_frame && d_frame_in_cmd == 2 && d_nbits == 19 && !flash_out[1]) begin
                hit = 1; break;
            end
        end
        if (!hit) begin
            total++; bad++;
            $display("FAIL rst_trigger: PP bit 20 not reached");
        end
        #2 resetn = 1'b0;
        #1;
        check("midrst_oeb", 64'(flash_oeb), 64'(6'h3F));
        check("midrst_out", 64'(flash_out), 64'(6'h00));
        check("midrst_active", 64'(active), 64'(0));
        dc = done_cnt;
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_ready", 64'(cmd_ready), 64'(1));
        check("midrst_nodone", 64'(done_cnt), 64'(dc));

        // Back-to-back with cmd_valid held high throughout.
        slave_stat = '{8'h00};
        clear_logs();
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = 24'h000010;
        cmd_wdata = 32'hA5A5A5A5;
        wait_accept();
        cmd_addr  = 24'h00ABC8;
        cmd_wdata = 32'hDEADBEEF;
        wait_done(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done(e);
        check("b2b_falls", 64'(fall_q.size()), 64'(2));
        if (fall_q.size() == 2) check("b2b_restart", 64'(fall_q[1]), 64'(2));
        check("b2b_nbytes", 64'(log_bytes.size()), 64'(20));
        if (log_bytes.size() == 20) begin
            check("b2b_a2", 64'(log_bytes[12]), 64'(8'h00));
            check("b2b_a1", 64'(log_bytes[13]), 64'(8'hAB));
            check("b2b_a0", 64'(log_bytes[14]), 64'(8'hC8));
        end

        // Randomised commands and status sequences.
        for (int n = 0; n < 8; n++) begin
            int len;
            slave_stat.delete();
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) slave_stat.push_back(8'($urandom_range(0, 255)));
            send_cmd(24'($urandom), $urandom);
            wait_done(e);
        end
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
